// File: rtl/riscv_exec_unit_if.sv
// Operation-code package and handshake/operand bus for the RV32IM execution unit.
package riscv_exec_unit_pkg;
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_AND    = 5'd2,
        ALU_OR     = 5'd3,
        ALU_XOR    = 5'd4,
        ALU_SLL    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_SLT    = 5'd8,
        ALU_SLTU   = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } exec_fun_e;
endpackage

interface riscv_exec_unit_if #(
    parameter int WORD_LENGTH = 32
);
    logic                           in_valid;
    logic                           in_ready;
    riscv_exec_unit_pkg::exec_fun_e exec_fun;
    logic [WORD_LENGTH-1:0]         data1;
    logic [WORD_LENGTH-1:0]         data2;
    logic                           flush;
    logic                           out_valid;
    logic                           out_ready;
    logic [WORD_LENGTH-1:0]         alu_out;
    logic                           br_eq;
    logic                           br_lt;
    logic                           br_ltu;

    // Pipeline side: issues operations and consumes results
    modport master (
        output in_valid, exec_fun, data1, data2, flush, out_ready,
        input  in_ready, out_valid, alu_out, br_eq, br_lt, br_ltu
    );

    // Execution unit side
    modport slave (
        input  in_valid, exec_fun, data1, data2, flush, out_ready,
        output in_ready, out_valid, alu_out, br_eq, br_lt, br_ltu
    );
endinterface

// File: rtl/riscv_exec_unit.sv
// Handshaked RV32IM execution unit: single-cycle ALU ops, iterative
// shift-add multiply and restoring divide (one bit per cycle).
module riscv_exec_unit
    import riscv_exec_unit_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    riscv_exec_unit_if.slave bus
);
    localparam int W       = WORD_LENGTH;
    localparam int SHAMT_W = $clog2(WORD_LENGTH);
    localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(W - 1);
    localparam logic [W-1:0]       MOST_NEG  = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

    state_e           r_state, w_state_next;
    exec_fun_e        r_fun;
    logic [W-1:0]     r_hi, r_lo, r_opb, r_alu_out;
    logic [SHAMT_W-1:0] r_cnt;
    logic             r_neg, r_rneg;

    logic             w_accept, w_is_mul, w_is_div, w_a_sgn, w_b_sgn;
    logic             w_a_neg, w_b_neg, w_div_zero, w_div_ovf, w_div_special;
    logic [W-1:0]     w_a_mag, w_b_mag, w_quick;
    logic [SHAMT_W-1:0] w_shamt;
    logic [W:0]       w_sum, w_dsh, w_diff;
    logic [W-1:0]     w_mul_hi, w_mul_lo, w_div_hi, w_div_lo;
    logic [2*W-1:0]   w_prod, w_prod_fix;
    logic [W-1:0]     w_quo_fix, w_rem_fix, w_iter_result;
    logic             w_last;

    // Branch compare flags are purely combinational on the operands
    assign bus.br_eq  = (bus.data1 == bus.data2);
    assign bus.br_lt  = ($signed(bus.data1) < $signed(bus.data2));
    assign bus.br_ltu = (bus.data1 < bus.data2);
    assign bus.alu_out = r_alu_out;

    // Decode of the incoming request: op class, operand signs and magnitudes
    always_comb begin
        w_accept      = bus.in_valid && (r_state == S_IDLE) && !bus.flush;
        w_is_mul      = bus.exec_fun inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU};
        w_is_div      = bus.exec_fun inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        w_a_sgn       = bus.exec_fun inside {ALU_MULH, ALU_MULHSU, ALU_DIV, ALU_REM};
        w_b_sgn       = bus.exec_fun inside {ALU_MULH, ALU_DIV, ALU_REM};
        w_a_neg       = w_a_sgn && bus.data1[W-1];
        w_b_neg       = w_b_sgn && bus.data2[W-1];
        w_a_mag       = w_a_neg ? -bus.data1 : bus.data1;
        w_b_mag       = w_b_neg ? -bus.data2 : bus.data2;
        w_div_zero    = (bus.data2 == '0);
        w_div_ovf     = w_b_sgn && (bus.data1 == MOST_NEG) && (bus.data2 == '1);
        w_div_special = w_is_div && (w_div_zero || w_div_ovf);
        w_shamt       = bus.data2[SHAMT_W-1:0];
    end

    // Single-cycle results, including the divide special cases
    always_comb begin
        w_quick = '0;
        case (bus.exec_fun)
            ALU_ADD:  w_quick = bus.data1 + bus.data2;
            ALU_SUB:  w_quick = bus.data1 - bus.data2;
            ALU_AND:  w_quick = bus.data1 & bus.data2;
            ALU_OR:   w_quick = bus.data1 | bus.data2;
            ALU_XOR:  w_quick = bus.data1 ^ bus.data2;
            ALU_SLL:  w_quick = bus.data1 << w_shamt;
            ALU_SRL:  w_quick = bus.data1 >> w_shamt;
            ALU_SRA:  w_quick = $signed(bus.data1) >>> w_shamt;
            ALU_SLT:  w_quick = {{(W-1){1'b0}}, $signed(bus.data1) < $signed(bus.data2)};
            ALU_SLTU: w_quick = {{(W-1){1'b0}}, bus.data1 < bus.data2};
            ALU_DIV, ALU_DIVU: w_quick = w_div_zero ? '1 : bus.data1;
            ALU_REM, ALU_REMU: w_quick = w_div_zero ? bus.data1 : '0;
            default:  w_quick = '0;
        endcase
    end

    // One iteration step for both shift-add multiply and restoring divide
    always_comb begin
        w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
        w_dsh    = {r_hi, r_lo[W-1]};
        w_diff   = w_dsh - {1'b0, r_opb};
        w_mul_hi = w_sum[W:1];
        w_mul_lo = {w_sum[0], r_lo[W-1:1]};
        w_div_hi = w_diff[W] ? w_dsh[W-1:0] : w_diff[W-1:0];
        w_div_lo = {r_lo[W-2:0], ~w_diff[W]};
        w_last   = (r_cnt == LAST_ITER);
    end

    // Sign fix-up and word select applied on the final iteration
    always_comb begin
        w_prod        = {w_mul_hi, w_mul_lo};
        w_prod_fix    = r_neg ? -w_prod : w_prod;
        w_quo_fix     = r_neg ? -w_div_lo : w_div_lo;
        w_rem_fix     = r_rneg ? -w_div_hi : w_div_hi;
        w_iter_result = '0;
        case (r_fun)
            ALU_MUL:                          w_iter_result = w_prod_fix[W-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  w_iter_result = w_prod_fix[2*W-1:W];
            ALU_DIV, ALU_DIVU:                w_iter_result = w_quo_fix;
            ALU_REM, ALU_REMU:                w_iter_result = w_rem_fix;
            default:                          w_iter_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next-state logic; flush overrides everything
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) begin
                if (w_div_special)  w_state_next = S_DONE;
                else if (w_is_mul)  w_state_next = S_MUL;
                else if (w_is_div)  w_state_next = S_DIV;
                else                w_state_next = S_DONE;
            end
            S_MUL, S_DIV: if (w_last) w_state_next = S_DONE;
            S_DONE: if (bus.out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (bus.flush) w_state_next = S_IDLE;
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready  = (r_state == S_IDLE);
        bus.out_valid = (r_state == S_DONE);
    end

    // Operand latch, iteration registers and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fun     <= ALU_ADD;
            r_hi      <= '0;
            r_lo      <= '0;
            r_opb     <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_rneg    <= 1'b0;
            r_alu_out <= '0;
        end else if (w_accept) begin
            r_fun  <= bus.exec_fun;
            r_hi   <= '0;
            r_lo   <= w_a_mag;
            r_opb  <= w_b_mag;
            r_cnt  <= '0;
            r_neg  <= w_a_neg ^ w_b_neg;
            r_rneg <= w_a_neg;
            if (!(w_is_mul || w_is_div) || w_div_special) r_alu_out <= w_quick;
        end else if ((r_state == S_MUL || r_state == S_DIV) && !bus.flush) begin
            r_hi  <= (r_state == S_MUL) ? w_mul_hi : w_div_hi;
            r_lo  <= (r_state == S_MUL) ? w_mul_lo : w_div_lo;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) r_alu_out <= w_iter_result;
        end
    end
endmodule

// File: tb/tb_riscv_exec_unit.sv
// Scoreboard testbench for riscv_exec_unit (WORD_LENGTH = 32).
module tb_riscv_exec_unit;
    import riscv_exec_unit_pkg::*;

    localparam int W = 32;

    typedef struct {
        exec_fun_e   f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        int          lat;
    } op_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_exec_unit_if #(.WORD_LENGTH(W)) bus();
    riscv_exec_unit #(.WORD_LENGTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge and record its expected result
    task automatic issue(input exec_fun_e f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e);
        bus.exec_fun = f;
        bus.data1    = a;
        bus.data2    = b;
        bus.in_valid = 1'b1;
        exp_q.push_back(e);
        step();
        bus.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid; lat counts cycles from the accept edge
    task automatic wait_out(output int lat, output bit busy_ok);
        lat = 1;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            step();
            lat++;
        end
        if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
    endtask

    function automatic logic [31:0] model(exec_fun_e f, logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        logic [4:0]  sh;
        sh = b[4:0];
        p = '0;
        model = '0;
        case (f)
            ALU_ADD:  model = a + b;
            ALU_SUB:  model = a - b;
            ALU_AND:  model = a & b;
            ALU_OR:   model = a | b;
            ALU_XOR:  model = a ^ b;
            ALU_SLL:  model = a << sh;
            ALU_SRL:  model = a >> sh;
            ALU_SRA:  model = $signed(a) >>> sh;
            ALU_SLT:  model = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: model = (a < b) ? 32'd1 : 32'd0;
            ALU_MUL:    begin p = {32'b0, a} * {32'b0, b};             model = p[31:0];  end
            ALU_MULH:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; model = p[63:32]; end
            ALU_MULHSU: begin p = {{32{a[31]}}, a} * {32'b0, b};       model = p[63:32]; end
            ALU_MULHU:  begin p = {32'b0, a} * {32'b0, b};             model = p[63:32]; end
            ALU_DIV: begin
                if (b == 0) model = '1;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = a;
                else model = $signed(a) / $signed(b);
            end
            ALU_DIVU: model = (b == 0) ? 32'hFFFFFFFF : a / b;
            ALU_REM: begin
                if (b == 0) model = a;
                else if (a == 32'h80000000 && b == 32'hFFFFFFFF) model = '0;
                else model = $signed(a) % $signed(b);
            end
            ALU_REMU: model = (b == 0) ? a : a % b;
            default:  model = '0;
        endcase
    endfunction

    function automatic int model_lat(exec_fun_e f, logic [31:0] a, logic [31:0] b);
        bit ovf;
        ovf = (f == ALU_DIV || f == ALU_REM) && a == 32'h80000000 && b == 32'hFFFFFFFF;
        if (f inside {ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU}) return W + 1;
        if (f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU})
            return (b == 0 || ovf) ? 1 : W + 1;
        return 1;
    endfunction

    task automatic test_reset();
        bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
        bus.exec_fun = ALU_ADD; bus.data1 = '0; bus.data2 = '0;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.alu_out !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b alu_out=%h required 1 0 00000000",
                     bus.in_ready, bus.out_valid, bus.alu_out);
        end
        step(); step();
        #3 rst_n = 1'b1;
        step();
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", bus.in_ready);
        end
        $display("reset: in_ready=%b out_valid=%b alu_out=%h", bus.in_ready, bus.out_valid, bus.alu_out);
    endtask

    task automatic test_br_flags();
        bus.data1 = 32'hFFFFFFFF; bus.data2 = 32'h1;
        #1;
        n_vec++;
        if ({bus.br_eq, bus.br_lt, bus.br_ltu} !== 3'b010) begin
            n_err++;
            $display("FAIL br_flags_slt: eq/lt/ltu=%b%b%b required 010", bus.br_eq, bus.br_lt, bus.br_ltu);
        end
        bus.data1 = 32'h1234; bus.data2 = 32'h1234;
        #1;
        n_vec++;
        if ({bus.br_eq, bus.br_lt, bus.br_ltu} !== 3'b100) begin
            n_err++;
            $display("FAIL br_flags_eq: eq/lt/ltu=%b%b%b required 100", bus.br_eq, bus.br_lt, bus.br_ltu);
        end
        $display("br flags: eq=%b lt=%b ltu=%b", bus.br_eq, bus.br_lt, bus.br_ltu);
        step();
    endtask

    // Runs a table of operations through the scoreboard
    task automatic test_ops(input string tag, input op_t tbl[$]);
        int lat;
        bit busy_ok;
        logic [31:0] e;
        foreach (tbl[i]) begin
            issue(tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].e);
            wait_out(lat, busy_ok);
            e = exp_q.pop_front();
            n_vec++;
            if (bus.alu_out !== e) begin
                n_err++;
                $display("FAIL %s_value[%0d] %s: got %h required %h", tag, i, tbl[i].f.name(), bus.alu_out, e);
            end
            n_vec++;
            if (lat != tbl[i].lat) begin
                n_err++;
                $display("FAIL %s_latency[%0d] %s: got %0d required %0d", tag, i, tbl[i].f.name(), lat, tbl[i].lat);
            end
            if (tbl[i].lat > 1) begin
                n_vec++;
                if (!busy_ok) begin
                    n_err++;
                    $display("FAIL %s_in_ready_busy[%0d]: in_ready went high before handshake, required 0", tag, i);
                end
            end
            $display("%s %s a=%h b=%h -> %h lat=%0d", tag, tbl[i].f.name(), tbl[i].a, tbl[i].b, bus.alu_out, lat);
            step();
        end
    endtask

    task automatic test_simple();
        op_t t[$];
        t.push_back('{ALU_ADD,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1});
        t.push_back('{ALU_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1});
        t.push_back('{ALU_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1});
        t.push_back('{ALU_SRA,  32'h80000000, 32'h24,       32'hF8000000, 1});
        t.push_back('{ALU_SUB,  32'h0,        32'h1,        32'hFFFFFFFF, 1});
        t.push_back('{ALU_SLL,  32'h00000003, 32'h1F,       32'h80000000, 1});
        t.push_back('{ALU_SRL,  32'h80000000, 32'h21,       32'h40000000, 1});
        t.push_back('{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1});
        t.push_back('{exec_fun_e'(5'd25), 32'h12345678, 32'h1, 32'h0,     1});
        test_ops("simple", t);
    endtask

    task automatic test_muldiv();
        op_t t[$];
        t.push_back('{ALU_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33});
        t.push_back('{ALU_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33});
        t.push_back('{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33});
        t.push_back('{ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33});
        t.push_back('{ALU_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 33});
        t.push_back('{ALU_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 33});
        t.push_back('{ALU_DIVU,   32'h7,        32'h2,        32'h3,        33});
        t.push_back('{ALU_DIV,    32'h5,        32'h0,        32'hFFFFFFFF, 1});
        t.push_back('{ALU_REM,    32'h5,        32'h0,        32'h5,        1});
        t.push_back('{ALU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
        t.push_back('{ALU_REM,    32'h80000000, 32'hFFFFFFFF, 32'h0,        1});
        test_ops("muldiv", t);
    endtask

    task automatic test_back_to_back();
        op_t t[$];
        exec_fun_e f;
        logic [31:0] a, b;
        for (int i = 0; i < 14; i++) begin
            f = exec_fun_e'($urandom_range(0, 17));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 40);
                default: b = $urandom;
            endcase
            t.push_back('{f, a, b, model(f, a, b), model_lat(f, a, b)});
        end
        test_ops("b2b", t);
    endtask

    task automatic test_backpressure();
        logic [31:0] e;
        bit ok;
        bus.out_ready = 1'b0;
        issue(ALU_ADD, 32'h3, 32'h4, 32'h7);
        n_vec++;
        if (bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_valid: out_valid=%b required 1", bus.out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            ok = (bus.out_valid === 1'b1) && (bus.alu_out === 32'h7) && (bus.in_ready === 1'b0);
            n_vec++;
            if (!ok) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: out_valid=%b alu_out=%h in_ready=%b required 1 00000007 0",
                         i, bus.out_valid, bus.alu_out, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        e = exp_q.pop_front();
        n_vec++;
        if (bus.alu_out !== e) begin
            n_err++;
            $display("FAIL bp_value: got %h required %h", bus.alu_out, e);
        end
        $display("backpressure ADD -> %h held 3 cycles", bus.alu_out);
        step();
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        issue(ALU_AND, 32'hF0, 32'h3C, 32'h30);
        e = exp_q.pop_front();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.alu_out !== e) begin
            n_err++;
            $display("FAIL bp_next_accept: out_valid=%b alu_out=%h required 1 %h", bus.out_valid, bus.alu_out, e);
        end
        $display("backpressure follow-up AND -> %h", bus.alu_out);
        step();
    endtask

    task automatic test_flush();
        bit seen;
        issue(ALU_DIVU, 32'd100, 32'd7, 32'd14);
        for (int i = 0; i < 9; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_idle: in_ready=%b out_valid=%b required 1 0", bus.in_ready, bus.out_valid);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid === 1'b1) seen = 1'b1;
            step();
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL flush_no_result: out_valid rose=1 required 0");
        end
        exp_q.delete();
        $display("flush DIVU at N+10: in_ready=%b out_valid seen=%b", bus.in_ready, seen);
        bus.exec_fun = ALU_ADD; bus.data1 = 32'h1; bus.data2 = 32'h2;
        bus.in_valid = 1'b1; bus.flush = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_vs_valid: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
        $display("flush with in_valid in IDLE: out_valid=%b", bus.out_valid);
        step();
    endtask

    task automatic test_reset_mid();
        bit seen;
        logic [31:0] e;
        issue(ALU_ADD, 32'h1, 32'h1, 32'h2);
        e = exp_q.pop_front();
        n_vec++;
        if (bus.alu_out !== e) begin
            n_err++;
            $display("FAIL rst_pre_value: got %h required %h", bus.alu_out, e);
        end
        step();
        issue(ALU_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        step(); step(); step();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.alu_out !== 32'h0 || bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_async: out_valid=%b alu_out=%h in_ready=%b required 0 00000000 1",
                     bus.out_valid, bus.alu_out, bus.in_ready);
        end
        $display("reset mid MULHU: out_valid=%b alu_out=%h", bus.out_valid, bus.alu_out);
        step();
        #3 rst_n = 1'b1;
        exp_q.delete();
        step();
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid === 1'b1 || bus.in_ready !== 1'b1) seen = 1'b1;
            step();
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL rst_abort: result or busy seen after reset, required idle");
        end
        issue(ALU_OR, 32'h0F00, 32'h00F0, 32'h0FF0);
        e = exp_q.pop_front();
        n_vec++;
        if (bus.out_valid !== 1'b1 || bus.alu_out !== e) begin
            n_err++;
            $display("FAIL rst_after_op: out_valid=%b alu_out=%h required 1 %h", bus.out_valid, bus.alu_out, e);
        end
        $display("post-reset OR -> %h", bus.alu_out);
        step();
    endtask

    initial begin
        test_reset();
        test_br_flags();
        test_simple();
        test_muldiv();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/riscv_exec_unit.md
# riscv_exec_unit

Parametrised execution unit for the RV32IM pipeline. It replaces the single-cycle ADD/SLT ALU with a handshaked unit that covers the full RV32I ALU operation set plus the RV32M multiply/divide operations. Simple operations complete in one cycle; multiply and divide are computed iteratively over WORD_LENGTH cycles. It sits in the EX stage between operand select and the EX/MEM register, and stalls the pipeline through valid/ready.

## Interface
- WORD_LENGTH, 32, datapath width; any value ≥ 4.
- SHAMT_W, $clog2(WORD_LENGTH), shift-amount bits taken from data2 (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request.
- exec_fun  in  EXEC_FUN  operation. Legal values: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU.
- data1, data2  in  WORD_LENGTH  operands; sampled only on acceptance.
- flush  in  1  synchronous kill of any in-flight operation.
- out_valid  out  1  alu_out holds a result.
- out_ready  in  1  consumer takes the result.
- alu_out  out  WORD_LENGTH  registered result.
- br_eq, br_lt, br_ltu  out  1 each  combinational data1==data2, signed <, unsigned <. These do not depend on state.

## Operation
- Acceptance is in_valid && in_ready && !flush. Operands and exec_fun are latched on acceptance.
- States and transitions:
  - IDLE → DONE: accepted simple op.
  - IDLE → DONE: special-case divide.
  - IDLE → MUL or DIV: accepted mul/div op.
  - MUL/DIV → DONE: after WORD_LENGTH iterations.
  - DONE → IDLE: when out_ready is high.
- in_ready is 1 only in IDLE.
- out_valid is 1 only in DONE.
- Simple ops:
  - Arithmetic wraps modulo 2^WORD_LENGTH.
  - Shifts use data2[SHAMT_W-1:0]; SRA replicates the sign bit.
  - SLT/SLTU return zero-extended 0/1.
  - Illegal exec_fun returns 0 in one cycle.
- Multiply:
  - Radix-2 shift-add on operand magnitudes, one iteration per cycle, producing a 2·WORD_LENGTH-bit product.
  - The product is negated at completion when the result sign is negative.
  - Signedness per op: MULH treats both operands as signed; MULHSU treats data1 as signed and data2 as unsigned; MUL and MULHU treat both as unsigned.
  - MUL returns the low word; MULH, MULHSU and MULHU return the high word.
- Divide:
  - Restoring divide on magnitudes, one quotient bit per cycle.
  - Quotient sign is sign(data1) XOR sign(data2); remainder sign is sign(data1). Applies to signed ops only.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Divide special cases bypass iteration and go to DONE directly:
  - divisor == 0: quotient = all ones, remainder = data1.
  - Signed ops with data1 = most-negative and data2 = -1: quotient = data1, remainder = 0.
- Flush:
  - In any state, next state is IDLE and out_valid is 0 next cycle. Any pending result is discarded.
  - Flush takes priority over a simultaneous in_valid; that request is not accepted.
- out_ready is ignored outside DONE.

## Timing
- Reset (asynchronous, immediate): state = IDLE, out_valid = 0, alu_out = 0, all iteration registers = 0. in_ready = 1 after reset.
- Reset mid-operation aborts it with no result.
- Latency is measured from the accept edge, cycle N:
  - Simple op or divide special case: out_valid rises at N+1.
  - MUL/DIV family: out_valid rises at N+WORD_LENGTH+1 (N+33 for WORD_LENGTH = 32).
- alu_out is stable for as long as out_valid && !out_ready.
- Back-to-back operation:
  - A result consumed at cycle M returns the unit to IDLE at M+1.
  - The next accept can occur at M+1.
  - Sustained simple-op throughput is therefore one op per two cycles.
- br_* flags have zero latency and are valid whenever data1/data2 are valid.

## Test plan
- Simple ops, WORD_LENGTH = 32, out_ready tied high:
  - ADD 0x7FFFFFFF + 1 → 0x80000000 at N+1.
  - SLT 0xFFFFFFFF, 1 → 1; SLTU same operands → 0.
  - SRA 0x80000000 by 0x24 → 0xF8000000.
  - br_lt = 1, br_ltu = 0 for the SLT operands.
- Multiply, data1 = data2 = 0xFFFFFFFF:
  - MUL → 0x00000001; MULH → 0x00000000; MULHU → 0xFFFFFFFE; MULHSU → 0xFFFFFFFF.
  - out_valid rises exactly at N+33; in_ready stays 0 from N+1 through the DONE handshake.
- Divide:
  - DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 7/2 → 3, each at N+33.
  - DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 5, at N+1.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, at N+1.
- Backpressure: hold out_ready low for 3 cycles in DONE → alu_out and out_valid unchanged, in_ready 0; release → IDLE next cycle and a new accept succeeds.
- Flush: assert flush at N+10 of a DIVU → out_valid never rises, in_ready = 1 at N+11. Flush coincident with in_valid in IDLE → no acceptance.
- Reset: drop rst_n at N+5 of a MULHU → out_valid and alu_out go to 0 without waiting for a clock edge. After release the unit is in IDLE with in_ready = 1.
